// File: rtl/pwm_audio_dac_if.sv
// Sample stream interface feeding the PWM audio DAC.
// Valid/ready: the master holds s_data stable while s_valid is high; a
// transfer happens on every rising clk edge where s_valid && s_ready are
// both high. s_data is don't-care whenever no transfer happens.
interface pwm_audio_dac_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/pwm_audio_dac.sv
// PWM audio output stage: buffers playback samples in a small FIFO, paces
// them out at a fixed sample rate, applies shift-based volume around
// midscale and drives a 1-bit PWM pin whose duty only changes on frame
// boundaries.
module pwm_audio_dac #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_DIV = 1000,
  parameter int PREFILL    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  pwm_audio_dac_if.slave                s,
  input  logic [2:0]                    vol_shift,
  output logic                          pwm_out,
  output logic                          playing,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_cnt,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(SAMPLE_DIV);

  localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [LW-1:0]     FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]     PRE_LVL  = LW'(PREFILL);
  localparam logic [DW-1:0]     DIV_LAST = DW'(SAMPLE_DIV - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PREFILL = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DW-1:0]     div_cnt;
  logic [DATA_W-1:0] sample_reg;
  logic [2:0]        vol_reg;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] duty;
  logic [DATA_W-1:0] pwm_cnt;

  logic                     push;
  logic                     tick;
  logic                     pop;
  logic                     underrun;
  logic                     fifo_empty;
  logic signed [DATA_W-1:0] vol_d;
  logic signed [DATA_W-1:0] vol_a;
  logic [DATA_W-1:0]        target_next;
  logic [DATA_W-1:0]        pwm_cnt_next;
  logic [DATA_W-1:0]        duty_next;

  // Ready is also forced low while reset is held so the pin reads idle then.
  assign s.s_ready  = enable && !reset && (fifo_level != FULL_LVL);
  assign push       = s.s_valid && s.s_ready;
  assign fifo_empty = (fifo_level == '0);
  assign tick       = enable && (state == ST_RUN) && (div_cnt == DIV_LAST);
  // No bypass: an empty FIFO at the tick is an underrun even if a push lands.
  assign pop        = tick && !fifo_empty;
  assign underrun   = tick && fifo_empty;

  assign playing   = (state == ST_RUN);
  assign dbg_state = state;

  // Playback state machine: IDLE -> PREFILL -> RUN, back to PREFILL on underrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (!enable) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state <= ST_PREFILL;
        ST_PREFILL: if (fifo_level >= PRE_LVL) state <= ST_RUN;
        ST_RUN:     if (underrun) state <= ST_PREFILL;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Sample-rate divider; held at zero outside RUN so RUN always starts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!enable || state != ST_RUN || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // FIFO pointers and occupancy counter; disabling flushes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (!enable) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s.s_data;
  end

  // Current sample and the volume shift captured with it at each pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_reg <= MID;
      vol_reg    <= '0;
    end else if (!enable || state != ST_RUN) begin
      sample_reg <= MID;
    end else if (pop) begin
      sample_reg <= mem[rd_ptr];
      vol_reg    <= vol_shift;
    end else if (underrun) begin
      sample_reg <= MID;
    end
  end

  // Saturating underrun counter; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (underrun && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  // Volume: subtracting midscale is an MSB flip, and the signed result fits in
  // DATA_W bits, so the shift and the re-centring stay DATA_W wide and can
  // never leave 0..2^DATA_W-1.
  always_comb begin
    vol_d       = signed'({~sample_reg[DATA_W-1], sample_reg[DATA_W-2:0]});
    vol_a       = vol_d >>> vol_reg;
    target_next = {~vol_a[DATA_W-1], vol_a[DATA_W-2:0]};
  end

  // Registered attenuated target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target <= MID;
    end else begin
      target <= target_next;
    end
  end

  // Next PWM counter and duty; duty only reloads on the last count of a frame.
  always_comb begin
    pwm_cnt_next = enable ? pwm_cnt + DATA_W'(1) : '0;
    duty_next    = duty;
    if (!enable) begin
      duty_next = '0;
    end else if (pwm_cnt == '1) begin
      duty_next = target;
    end
  end

  // PWM frame counter, duty and registered output pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt_next;
      duty    <= duty_next;
      pwm_out <= (pwm_cnt_next < duty_next);
    end
  end

endmodule

// File: doc/pwm_audio_dac.md
Name: pwm_audio_dac

Overview:
- Playback output stage that consumes the 8-bit capture-RAM playback samples and drives a 1-bit PWM audio pin.
- Buffers samples in a small FIFO and paces them out at a fixed sample rate derived from clk.
- Applies shift-based volume attenuation around midscale.
- Updates the duty cycle only on PWM frame boundaries, so the output never glitches.

Parameters:
- DATA_W, 8: sample width; the PWM frame is 2^DATA_W clk cycles.
- FIFO_DEPTH, 16: sample FIFO entries; must be a power of 2 and at least 4.
- SAMPLE_DIV, 1000: clk cycles per output sample (44 MHz / 1000 = 44 kHz); must be at least 2.
- PREFILL, 8: FIFO level required before playback starts or resumes; must be between 1 and FIFO_DEPTH.

Ports:
- clk  in  1  system clock (44 MHz)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  playback enable; low flushes the block and idles it
- s_data  in  DATA_W  unsigned sample, midscale 2^(DATA_W-1)
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept a sample
- vol_shift  in  3  attenuation shift, 0..7; sampled at each pop
- pwm_out  out  1  PWM audio output
- playing  out  1  high in RUN state
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- underrun_cnt  out  16  saturating count of underrun events

Behaviour:
- Reset (asynchronous) and enable=0 (synchronous) give identical values:
  - FIFO empty; state IDLE; pwm_cnt=0; div_cnt=0; sample_reg=midscale.
  - duty=0, so pwm_out=0 with no hum while disabled.
  - s_ready=0; playing=0.
  - underrun_cnt=0 on reset only; enable=0 does not clear it.
- Handshake:
  - s_ready = enable && (fifo_level != FIFO_DEPTH).
  - Push occurs on a cycle where s_valid && s_ready.
  - s_data is ignored when no push occurs.
- FIFO:
  - Circular buffer with wrapping pointers; level is maintained as a counter.
  - A push and a pop in the same cycle leave the level unchanged.
  - No bypass path: a pop on an empty FIFO is an underrun, even if a push lands in the same cycle.
- Sample tick:
  - div_cnt counts 0..SAMPLE_DIV-1 and wraps, only while state is RUN.
  - tick is asserted when div_cnt == SAMPLE_DIV-1.
- FSM:
  - IDLE: entered on reset or enable=0. Goes to PREFILL when enable=1.
  - PREFILL: no pops; sample_reg is held at midscale. Goes to RUN when fifo_level >= PREFILL, with div_cnt=0 on entry.
  - RUN, on tick with FIFO non-empty: pop the head into sample_reg on the next edge.
  - RUN, on tick with FIFO empty (underrun): sample_reg <= midscale; underrun_cnt += 1, saturating at 0xFFFF; go to PREFILL.
  - enable=0 in any state: go to IDLE on the next edge and flush.
- Volume arithmetic:
  - d = sample_reg - midscale, sign-extended to DATA_W+1 bits.
  - a = d >>> vol_shift (arithmetic shift).
  - target = a + midscale, truncated to DATA_W bits. It always lies in 0..2^DATA_W-1, so no clipping is needed.
  - target is registered one cycle after sample_reg changes.
- PWM:
  - pwm_cnt is a free-running DATA_W-bit counter while enable=1.
  - duty <= target only on the cycle where pwm_cnt == 2^DATA_W-1.
  - pwm_out is registered: pwm_out <= (pwm_cnt_next < duty_next).
  - duty=0 gives constant 0; duty=255 gives 255 of 256 cycles high.
- Latency: from the tick, sample_reg updates at +1 and target at +2; the duty takes effect at the next PWM frame start (at most 2^DATA_W+2 cycles).
- playing = (state == RUN).

Test Plan:
- Reset mid-operation: in RUN with level=5, assert reset for 1 cycle asynchronously -> all outputs take reset values immediately; level=0; underrun_cnt=0; pwm_out=0.
- Prefill: enable=1; push 7 samples of 0xC0 -> playing=0 and level=7. Push an 8th -> playing=1 the next cycle. First tick pops 0xC0 at div_cnt=999; the next frame has 192 of 256 cycles high.
- Full FIFO: with enable=1 and no ticks elapsed (PREFILL=16 override), hold s_valid=1 for 20 cycles -> exactly 16 pushes; s_ready=0 from level=16; excess data not stored.
- Underrun: in RUN, let the FIFO drain with no pushes -> on the first empty tick, underrun_cnt 0->1; state goes to PREFILL; pwm_out reaches 128 of 256 duty; playing=0.
- Volume: sample 0x00 with vol_shift=0 -> duty 0. vol_shift=1 -> 64. vol_shift=7 -> 127. Sample 0xFF with vol_shift=1 -> 191.
- Glitch-free update: change target mid-frame (pwm_cnt=100) -> that frame's high time is unchanged; the new duty applies from pwm_cnt=0 of the next frame.
